// File: rtl/rotl_pkg.sv
// rotl_pkg: shared state encoding and size defaults for the rotate sequencer.
package rotl_pkg;
    localparam int WIDTH_DEF = 8;
    localparam int AMT_W_DEF = 3;
    localparam int OPCNT_W = 16;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, HOLD = 2'd2} state_t;
endpackage

// File: rtl/rotl_sequencer_if.sv
// rotl_sequencer_if: operand-in and result-out valid/ready handshakes.
interface rotl_sequencer_if #(parameter int WIDTH = 8, parameter int AMT_W = 3);
    logic in_valid;
    logic in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic out_valid;
    logic out_ready;
    logic [WIDTH-1:0] out_data;
    modport master (output in_valid, in_data, in_amt, out_ready, input in_ready, out_valid, out_data);
    modport slave (input in_valid, in_data, in_amt, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/rotl_step.sv
// rotl_step: combinational single-bit circular left rotate.
module rotl_step #(parameter int WIDTH = 8) (
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    assign q = {d[WIDTH-2:0], d[WIDTH-1]};
endmodule

// File: rtl/rotl_sequencer.sv
// rotl_sequencer: multi-cycle rotate-left, one bit per clock, with in/out handshakes.
// Define ROTSEQ_OPCOUNT_EN to add a saturating completed-transaction counter (op_count).
module rotl_sequencer
    import rotl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AMT_W = AMT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    rotl_sequencer_if.slave bus,
`ifdef ROTSEQ_OPCOUNT_EN
    output logic [OPCNT_W-1:0] op_count,
`endif
    output logic busy
);
    state_t state;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] step_d;
    logic [AMT_W-1:0] cnt_q;

    rotl_step #(.WIDTH(WIDTH)) u_step (.d(data_q), .q(step_d));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            data_q <= '0;
            cnt_q <= '0;
            busy <= 1'b0;
            bus.in_ready <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_data <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    data_q <= bus.in_data;
                    cnt_q <= bus.in_amt;
                    busy <= 1'b1;
                    bus.in_ready <= 1'b0;
                    // amount zero skips straight to presenting the operand
                    if (bus.in_amt == '0) begin
                        state <= HOLD;
                        bus.out_valid <= 1'b1;
                        bus.out_data <= bus.in_data;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    data_q <= step_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == AMT_W'(1)) begin
                        state <= HOLD;
                        bus.out_valid <= 1'b1;
                        bus.out_data <= step_d;
                    end
                end
                HOLD: if (bus.out_ready) begin
                    state <= IDLE;
                    busy <= 1'b0;
                    bus.in_ready <= 1'b1;
                    bus.out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ROTSEQ_OPCOUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) op_count <= '0;
        else if (bus.out_valid && bus.out_ready && op_count != '1) op_count <= op_count + 1'b1;
    end
`endif
endmodule

// File: tb/tb_rotl_sequencer.sv
// tb_rotl_sequencer: directed and random transactions against a rotate reference model.
// Build with ROTSEQ_OPCOUNT_EN to also check the completed-transaction counter.
module tb_rotl_sequencer;
    localparam int W = 8;
    localparam int AW = 3;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int passed = 0;
    int total = 0;
`ifdef ROTSEQ_OPCOUNT_EN
    logic [15:0] op_count;
    int exp_ops = 0;
`endif

    rotl_sequencer_if #(.WIDTH(W), .AMT_W(AW)) bus ();

    rotl_sequencer #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave),
`ifdef ROTSEQ_OPCOUNT_EN
        .op_count(op_count),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] rotl_ref(input logic [W-1:0] d, input int a);
        int v;
        v = int'(d);
        return W'((v << a) | (v >> (W - a)));
    endfunction

    // Drives one full transaction; junk keeps in_valid asserted with noise while busy.
    task automatic run_txn(input logic [W-1:0] d, input int a, input int hold, input bit junk);
        int n;
        int lat;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_data = d;
        bus.in_amt = AW'(a);
        @(posedge clk); #1;
        bus.in_valid = junk;
        bus.in_data = W'($urandom);
        bus.in_amt = AW'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            check("busy_shift", busy, 1);
            check("in_ready_shift", bus.in_ready, 0);
            bus.out_ready = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        bus.out_ready = 1'b0;
        check("latency", lat, a + 1);
        check("out_data", bus.out_data, rotl_ref(d, a));
        check("busy_hold", busy, 1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", bus.out_valid, 1);
            check("hold_data", bus.out_data, rotl_ref(d, a));
            check("hold_in_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("post_valid", bus.out_valid, 0);
        check("post_in_ready", bus.in_ready, 1);
        check("post_busy", busy, 0);
`ifdef ROTSEQ_OPCOUNT_EN
        if (exp_ops < 16'hFFFF) exp_ops++;
        check("op_count", op_count, exp_ops);
`endif
    endtask

    initial begin
        int lat;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_amt = '0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn(8'h81, 1, 0, 1'b0);
        run_txn(8'hA5, 0, 0, 1'b1);
        run_txn(8'h01, 7, 0, 1'b1);
        run_txn(8'h0F, 2, 5, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data = 8'hF0;
        bus.in_amt = 3'd5;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        repeat (2) begin
            @(posedge clk); #1;
            lat++;
        end
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_out_data", bus.out_data, 0);
        check("arst_in_ready", bus.in_ready, 1);
        check("arst_busy", busy, 0);
        #1 rst_n = 1'b1;
`ifdef ROTSEQ_OPCOUNT_EN
        exp_ops = 0;
        check("arst_op_count", op_count, 0);
`endif
        @(posedge clk); #1;
        run_txn(8'h12, 4, 0, 1'b0);
        for (int t = 0; t < 40; t++)
            run_txn(W'($urandom), int'($urandom_range(0, W - 1)), int'($urandom_range(0, 3)), 1'($urandom));
`ifdef ROTSEQ_OPCOUNT_EN
        force dut.op_count = 16'hFFFE;
        @(posedge clk); #1;
        release dut.op_count;
        exp_ops = 16'hFFFE;
        run_txn(8'h3C, 3, 0, 1'b0);
        run_txn(8'hC3, 0, 1, 1'b0);
        run_txn(8'h5A, 6, 0, 1'b1);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
